// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: round-robin sharing of one memory port between I-cache and D-cache masters.
// Revision 1.0 - initial release.
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_mem_read,
  input  logic              ic_mem_write,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  input  logic [DATA_W-1:0] ic_mem_wdata,
  output logic [DATA_W-1:0] ic_mem_rdata,
  output logic              ic_mem_ready,
  input  logic              dc_mem_read,
  input  logic              dc_mem_write,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [DATA_W-1:0] dc_mem_wdata,
  output logic [DATA_W-1:0] dc_mem_rdata,
  output logic              dc_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              gnt_ic,
  output logic              gnt_dc,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   last_gnt_d;
  logic   req_i, req_d, contended;
  logic   grant_i, grant_d;

  always_comb begin
    req_i     = ic_mem_read | ic_mem_write;
    req_d     = dc_mem_read | dc_mem_write;
    contended = req_i & req_d;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        // Under contention the master that did not win last time goes next.
        if (contended) begin
          grant_i = last_gnt_d;
          grant_d = ~last_gnt_d;
        end else begin
          grant_i = req_i;
          grant_d = req_d;
        end
        if (grant_i)      state_nxt = GNT_I;
        else if (grant_d) state_nxt = GNT_D;
      end
      GNT_I, GNT_D: if (mem_ready) state_nxt = TURN;
      TURN:         state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  assign gnt_ic       = (state == GNT_I);
  assign gnt_dc       = (state == GNT_D);
  assign ic_mem_ready = mem_ready & gnt_ic;
  assign dc_mem_ready = mem_ready & gnt_dc;
  assign ic_mem_rdata = mem_rdata;
  assign dc_mem_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_gnt_d   <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      conflict_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (grant_i) begin
        mem_read   <= ic_mem_read;
        mem_write  <= ic_mem_write;
        mem_addr   <= ic_mem_addr;
        mem_wdata  <= ic_mem_wdata;
        last_gnt_d <= 1'b0;
      end else if (grant_d) begin
        mem_read   <= dc_mem_read;
        mem_write  <= dc_mem_write;
        mem_addr   <= dc_mem_addr;
        mem_wdata  <= dc_mem_wdata;
        last_gnt_d <= 1'b1;
      end
      if ((gnt_ic || gnt_dc) && mem_ready) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
      if ((state == IDLE) && contended && (conflict_cnt != {CNT_W{1'b1}}))
        conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Directed self-checking bench for mem_port_arbiter (second instance with a 2-bit counter).
module tb_mem_port_arbiter;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              ic_mem_read, ic_mem_write, dc_mem_read, dc_mem_write;
  logic [ADDR_W-1:0] ic_mem_addr, dc_mem_addr;
  logic [DATA_W-1:0] ic_mem_wdata, dc_mem_wdata, mem_rdata;
  logic              mem_ready;
  logic [DATA_W-1:0] ic_mem_rdata, dc_mem_rdata, mem_wdata;
  logic              ic_mem_ready, dc_mem_ready, mem_read, mem_write, gnt_ic, gnt_dc;
  logic [ADDR_W-1:0] mem_addr;
  logic [CNT_W-1:0]  conflict_cnt;
  logic [DATA_W-1:0] s_ic_rdata, s_dc_rdata, s_wdata;
  logic              s_ic_ready, s_dc_ready, s_read, s_write, s_gnt_ic, s_gnt_dc;
  logic [ADDR_W-1:0] s_addr;
  logic [1:0]        s_cnt;

  int checks = 0;
  int passed = 0;

  localparam logic [DATA_W-1:0] WDATA_A = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ic_mem_read(ic_mem_read), .ic_mem_write(ic_mem_write), .ic_mem_addr(ic_mem_addr),
    .ic_mem_wdata(ic_mem_wdata), .ic_mem_rdata(ic_mem_rdata), .ic_mem_ready(ic_mem_ready),
    .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write), .dc_mem_addr(dc_mem_addr),
    .dc_mem_wdata(dc_mem_wdata), .dc_mem_rdata(dc_mem_rdata), .dc_mem_ready(dc_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .gnt_ic(gnt_ic), .gnt_dc(gnt_dc), .conflict_cnt(conflict_cnt)
  );

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .ic_mem_read(ic_mem_read), .ic_mem_write(ic_mem_write), .ic_mem_addr(ic_mem_addr),
    .ic_mem_wdata(ic_mem_wdata), .ic_mem_rdata(s_ic_rdata), .ic_mem_ready(s_ic_ready),
    .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write), .dc_mem_addr(dc_mem_addr),
    .dc_mem_wdata(dc_mem_wdata), .dc_mem_rdata(s_dc_rdata), .dc_mem_ready(s_dc_ready),
    .mem_read(s_read), .mem_write(s_write), .mem_addr(s_addr), .mem_wdata(s_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .gnt_ic(s_gnt_ic), .gnt_dc(s_gnt_dc), .conflict_cnt(s_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_mem_read = 0; ic_mem_write = 0; ic_mem_addr = '0; ic_mem_wdata = '0;
    dc_mem_read = 0; dc_mem_write = 0; dc_mem_addr = '0; dc_mem_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Advances until either grant is visible; ok=0 if none appears within the budget.
  task automatic wait_grant(output bit ok);
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      if (gnt_ic || gnt_dc) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0)
      $display("FAIL reset_cmd: read=%b write=%b want 0 0", mem_read, mem_write); else passed++;
    checks++; if (mem_addr !== '0 || mem_wdata !== '0)
      $display("FAIL reset_bus: addr=%h wdata=%h want 0", mem_addr, mem_wdata); else passed++;
    checks++; if (gnt_ic !== 1'b0 || gnt_dc !== 1'b0)
      $display("FAIL reset_gnt: ic=%b dc=%b want 0 0", gnt_ic, gnt_dc); else passed++;
    checks++; if (conflict_cnt !== '0 || s_cnt !== 2'd0)
      $display("FAIL reset_cnt: cnt=%0d sat=%0d want 0 0", conflict_cnt, s_cnt); else passed++;
  endtask

  task automatic test_single_read();
    apply_reset();
    ic_mem_read = 1; ic_mem_addr = 28'h0000010;
    tick(); // t1
    checks++; if (mem_read !== 1'b1 || mem_addr !== 28'h0000010 || gnt_ic !== 1'b1 || gnt_dc !== 1'b0)
      $display("FAIL single_grant: read=%b addr=%h gi=%b gd=%b want 1 0000010 1 0",
               mem_read, mem_addr, gnt_ic, gnt_dc); else passed++;
    ic_mem_addr = 28'h0000777;
    tick(); tick(); tick(); tick(); // t5
    checks++; if (mem_read !== 1'b1 || ic_mem_ready !== 1'b0)
      $display("FAIL single_wait: read=%b ready=%b want 1 0", mem_read, ic_mem_ready); else passed++;
    mem_ready = 1; mem_rdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    #1;
    checks++; if (ic_mem_ready !== 1'b1 || dc_mem_ready !== 1'b0 ||
                  ic_mem_rdata !== 128'h1111_2222_3333_4444_5555_6666_7777_8888)
      $display("FAIL single_ready: ic=%b dc=%b rdata=%h want 1 0 1111..8888",
               ic_mem_ready, dc_mem_ready, ic_mem_rdata); else passed++;
    tick(); // t6
    mem_ready = 0; ic_mem_read = 0;
    checks++; if (mem_read !== 1'b0 || ic_mem_ready !== 1'b0 || gnt_ic !== 1'b0)
      $display("FAIL single_turn: read=%b ready=%b gnt=%b want 0 0 0", mem_read, ic_mem_ready, gnt_ic); else passed++;
    tick(); // t7 idle: same master may be regranted
    ic_mem_read = 1; ic_mem_addr = 28'h0000020;
    checks++; if (gnt_ic !== 1'b0 || gnt_dc !== 1'b0)
      $display("FAIL single_idle: gi=%b gd=%b want 0 0", gnt_ic, gnt_dc); else passed++;
    tick();
    checks++; if (gnt_ic !== 1'b1 || mem_addr !== 28'h0000020)
      $display("FAIL single_regrant: gi=%b addr=%h want 1 0000020", gnt_ic, mem_addr); else passed++;
  endtask

  task automatic test_conflict_first();
    apply_reset();
    ic_mem_read = 1; ic_mem_addr = 28'h0000100;
    dc_mem_read = 1; dc_mem_addr = 28'h0000200;
    tick();
    checks++; if (gnt_dc !== 1'b1 || gnt_ic !== 1'b0 || mem_addr !== 28'h0000200)
      $display("FAIL conflict_first: gd=%b gi=%b addr=%h want 1 0 0000200", gnt_dc, gnt_ic, mem_addr); else passed++;
    checks++; if (conflict_cnt !== 16'd1)
      $display("FAIL conflict_cnt1: got %0d want 1", conflict_cnt); else passed++;
    mem_ready = 1;
    #1;
    checks++; if (dc_mem_ready !== 1'b1 || ic_mem_ready !== 1'b0)
      $display("FAIL conflict_ready: dc=%b ic=%b want 1 0", dc_mem_ready, ic_mem_ready); else passed++;
    tick(); // TURN
    mem_ready = 0; dc_mem_read = 0;
    tick(); // IDLE, only I requesting
    tick();
    checks++; if (gnt_ic !== 1'b1 || mem_addr !== 28'h0000100 || conflict_cnt !== 16'd1)
      $display("FAIL conflict_second: gi=%b addr=%h cnt=%0d want 1 0000100 1", gnt_ic, mem_addr, conflict_cnt); else passed++;
  endtask

  task automatic test_write_hold();
    apply_reset();
    dc_mem_write = 1; dc_mem_addr = 28'h00000A0; dc_mem_wdata = WDATA_A;
    tick();
    checks++; if (gnt_dc !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0 ||
                  mem_addr !== 28'h00000A0 || mem_wdata !== WDATA_A)
      $display("FAIL write_grant: gd=%b w=%b r=%b addr=%h wdata=%h", gnt_dc, mem_write, mem_read, mem_addr, mem_wdata); else passed++;
    dc_mem_addr = 28'h0000123; dc_mem_wdata = '1; dc_mem_read = 1;
    tick(); tick();
    checks++; if (mem_addr !== 28'h00000A0 || mem_wdata !== WDATA_A || mem_read !== 1'b0 || mem_write !== 1'b1)
      $display("FAIL write_hold: addr=%h wdata=%h r=%b w=%b want 00000A0 DEAD..BEEF 0 1",
               mem_addr, mem_wdata, mem_read, mem_write); else passed++;
    mem_ready = 1;
    #1;
    checks++; if (dc_mem_ready !== 1'b1)
      $display("FAIL write_ready: got %b want 1", dc_mem_ready); else passed++;
    tick();
    mem_ready = 0; dc_mem_write = 0; dc_mem_read = 0;
    checks++; if (mem_write !== 1'b0)
      $display("FAIL write_clear: got %b want 0", mem_write); else passed++;
  endtask

  task automatic test_alternate();
    bit ok;
    bit exp_d;
    apply_reset();
    ic_mem_read = 1; ic_mem_addr = 28'h0000300;
    dc_mem_read = 1; dc_mem_addr = 28'h0000400;
    for (int n = 0; n < 4; n++) begin
      exp_d = (n % 2 == 0);
      wait_grant(ok);
      checks++; if (!ok) $display("FAIL alt_timeout: txn %0d no grant", n); else passed++;
      checks++; if (gnt_dc !== exp_d || gnt_ic !== !exp_d)
        $display("FAIL alt_order: txn %0d gd=%b gi=%b want gd=%b", n, gnt_dc, gnt_ic, exp_d); else passed++;
      mem_ready = 1;
      #1;
      checks++; if (dc_mem_ready !== exp_d || ic_mem_ready !== !exp_d)
        $display("FAIL alt_ready: txn %0d dc=%b ic=%b want dc=%b", n, dc_mem_ready, ic_mem_ready, exp_d); else passed++;
      tick();
      mem_ready = 0;
      if (n == 3) begin
        ic_mem_read = 0; dc_mem_read = 0;
      end
    end
    checks++; if (conflict_cnt !== 16'd4)
      $display("FAIL alt_cnt: got %0d want 4", conflict_cnt); else passed++;
    tick(); // back to IDLE
  endtask

  task automatic test_reset_mid();
    ic_mem_read = 1; ic_mem_addr = 28'h0000500;
    tick();
    checks++; if (gnt_ic !== 1'b1 || mem_read !== 1'b1 || conflict_cnt !== 16'd4)
      $display("FAIL rmid_pre: gi=%b r=%b cnt=%0d want 1 1 4", gnt_ic, mem_read, conflict_cnt); else passed++;
    rst = 1;
    tick();
    rst = 0; ic_mem_read = 0;
    checks++; if (mem_read !== 1'b0 || gnt_ic !== 1'b0 || conflict_cnt !== '0)
      $display("FAIL rmid_after: r=%b gi=%b cnt=%0d want 0 0 0", mem_read, gnt_ic, conflict_cnt); else passed++;
    mem_ready = 1; mem_rdata = 128'hABCD;
    #1;
    checks++; if (ic_mem_ready !== 1'b0 || dc_mem_ready !== 1'b0 || dc_mem_rdata !== 128'hABCD)
      $display("FAIL rmid_stray: ic=%b dc=%b rdata=%h want 0 0 abcd", ic_mem_ready, dc_mem_ready, dc_mem_rdata); else passed++;
    tick();
    mem_ready = 0;
    checks++; if (gnt_ic !== 1'b0 || gnt_dc !== 1'b0)
      $display("FAIL rmid_idle: gi=%b gd=%b want 0 0", gnt_ic, gnt_dc); else passed++;
  endtask

  task automatic test_saturate();
    bit ok;
    logic [1:0] exp_sat;
    apply_reset();
    ic_mem_read = 1; dc_mem_read = 1;
    for (int n = 1; n <= 5; n++) begin
      wait_grant(ok);
      exp_sat = (n >= 3) ? 2'd3 : 2'(n);
      checks++; if (!ok) $display("FAIL sat_timeout: txn %0d no grant", n); else passed++;
      checks++; if (s_cnt !== exp_sat || conflict_cnt !== 16'(n))
        $display("FAIL sat_cnt: txn %0d sat=%0d cnt=%0d want %0d %0d", n, s_cnt, conflict_cnt, exp_sat, n); else passed++;
      mem_ready = 1;
      tick();
      mem_ready = 0;
    end
    ic_mem_read = 0; dc_mem_read = 0;
    tick(); tick();
    checks++; if (s_cnt !== 2'd3)
      $display("FAIL sat_hold: got %0d want 3", s_cnt); else passed++;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_conflict_first();
    test_write_hold();
    test_alternate();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
